// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and types for the writeback path.
//   XLEN      register data width
//   KEY_W     register index width
//   NUM_REGS  architectural register count (scoreboard width)
//   X0        index of the hardwired-zero register
//   wb_req_t  one writeback request {valid, key, value}
package rf_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned KEY_W    = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam logic [KEY_W-1:0] X0  = '0;

   typedef struct packed {
      logic             valid;
      logic [KEY_W-1:0] key;
      logic [XLEN-1:0]  value;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req        in   N        request vector
//   ptr        in   IdxW     index granted most recently; search starts at ptr+1
//   grant      out  N        one-hot grant (all zero when no request)
//   grant_idx  out  IdxW     index of the granted requester (0 when no grant)
module rr_arbiter #(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [IdxW-1:0] grant_idx
);

   always_comb begin
      int unsigned idx;
      logic        found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      // Visit ptr+1, ptr+2, ..., ptr (wrapping); first active request wins.
      for (int unsigned off = 1; off <= N; off++) begin
         idx = (int'(ptr) + off) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/rf_writeback_scheduler.sv
// rf_writeback_scheduler: shares the register file write port (portD) between NUM_REQ
// writeback requesters with round-robin valid/ready arbitration, and keeps a busy
// scoreboard that flags RAW/WAW hazards to the issue stage.
//   clk, reset                  clock, synchronous active-low reset
//   req_valid/key/value         per-requester writeback (flattened slices)
//   req_ready                   one-hot grant, transfer on valid & ready
//   rf_portD_enable/key/value   registered write port to the register file
//   rsv_valid, rsv_key          issue stage reserves a destination
//   chk_key1, chk_key2          source registers of the instruction at issue
//   hazard                      combinational stall request
//   busy_mask                   registered scoreboard, bit k = x_k pending
module rf_writeback_scheduler #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned XLEN    = rf_pkg::XLEN,
   parameter int unsigned KEY_W   = rf_pkg::KEY_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*KEY_W-1:0] req_key,
   input  logic [NUM_REQ*XLEN-1:0]  req_value,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rf_portD_enable,
   output logic [KEY_W-1:0]         rf_portD_key,
   output logic [XLEN-1:0]          rf_portD_value,
   input  logic                     rsv_valid,
   input  logic [KEY_W-1:0]         rsv_key,
   input  logic [KEY_W-1:0]         chk_key1,
   input  logic [KEY_W-1:0]         chk_key2,
   output logic                     hazard,
   output logic [31:0]              busy_mask
);

   import rf_pkg::*;

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IdxW-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [IdxW-1:0]     arb_idx;
   logic                any_grant;
   logic [KEY_W-1:0]    win_key;
   logic [XLEN-1:0]     win_value;
   logic                en_q, en_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic [XLEN-1:0]     value_q, value_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;

   rr_arbiter #(
      .N    (NUM_REQ),
      .IdxW (IdxW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // No handshake may complete while reset is held.
   assign req_ready = reset ? arb_grant : '0;
   assign any_grant = |req_ready;

   always_comb begin
      win_key   = '0;
      win_value = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            win_key   = req_key[i*KEY_W +: KEY_W];
            win_value = req_value[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      ptr_d   = ptr_q;
      en_d    = 1'b0;
      key_d   = key_q;
      value_d = value_q;
      busy_d  = busy_q;
      if (any_grant) begin
         ptr_d = arb_idx;
         // x0 writes complete the handshake but never reach the register file.
         if (win_key != X0) begin
            en_d    = 1'b1;
            key_d   = win_key;
            value_d = win_value;
            busy_d[win_key] = 1'b0;
         end
      end
      // Applied after the clear so a same-cycle reserve keeps the new producer pending.
      if (rsv_valid && rsv_key != X0) begin
         busy_d[rsv_key] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q   <= IdxW'(NUM_REQ - 1);
         en_q    <= 1'b0;
         key_q   <= '0;
         value_q <= '0;
         busy_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         en_q    <= en_d;
         key_q   <= key_d;
         value_q <= value_d;
         busy_q  <= busy_d;
      end
   end

   assign rf_portD_enable = en_q;
   assign rf_portD_key    = key_q;
   assign rf_portD_value  = value_q;
   assign busy_mask       = busy_q;

   // busy_q[0] is held at zero, so the x0 terms need no extra qualification.
   assign hazard = busy_q[chk_key1] | busy_q[chk_key2] | (rsv_valid & busy_q[rsv_key]);

   // Issue stage must not reserve a destination that already has a producer outstanding.
   a_rsv_not_busy : assert property (@(posedge clk) disable iff (!reset)
      !(rsv_valid && rsv_key != X0 && busy_q[rsv_key]));

   // A pending request must stay valid and stable until it is granted.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
      a_req_hold : assert property (@(posedge clk) disable iff (!reset)
         (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_key[i*KEY_W +: KEY_W])
                          && $stable(req_value[i*XLEN +: XLEN])));
   end

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// tb_rf_writeback_scheduler: directed, table-driven bench for rf_writeback_scheduler
// (NUM_REQ=2). Each vector is one clock cycle: combinational outputs are compared
// before the edge, registered outputs just after it.
module tb_rf_writeback_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [9:0]  req_key;
   logic [63:0] req_value;
   logic [1:0]  req_ready;
   logic        rf_portD_enable;
   logic [4:0]  rf_portD_key;
   logic [31:0] rf_portD_value;
   logic        rsv_valid;
   logic [4:0]  rsv_key;
   logic [4:0]  chk_key1;
   logic [4:0]  chk_key2;
   logic        hazard;
   logic [31:0] busy_mask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rf_writeback_scheduler #(
      .NUM_REQ (2),
      .XLEN    (32),
      .KEY_W   (5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_key         (req_key),
      .req_value       (req_value),
      .req_ready       (req_ready),
      .rf_portD_enable (rf_portD_enable),
      .rf_portD_key    (rf_portD_key),
      .rf_portD_value  (rf_portD_value),
      .rsv_valid       (rsv_valid),
      .rsv_key         (rsv_key),
      .chk_key1        (chk_key1),
      .chk_key2        (chk_key2),
      .hazard          (hazard),
      .busy_mask       (busy_mask)
   );

   typedef struct {
      string       name;
      logic [1:0]  valid;
      logic [4:0]  k0;
      logic [31:0] v0;
      logic [4:0]  k1;
      logic [31:0] v1;
      logic        rv;
      logic [4:0]  rk;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic [1:0]  e_ready;
      logic        e_hazard;
      logic        e_en;
      logic [4:0]  e_key;
      logic [31:0] e_value;
      logic [31:0] e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [4:0] k0, input logic [31:0] v0,
                        input logic [4:0] k1, input logic [31:0] v1,
                        input logic rv, input logic [4:0] rk,
                        input logic [4:0] c1, input logic [4:0] c2);
      req_valid = v;
      req_key   = {k1, k0};
      req_value = {v1, v0};
      rsv_valid = rv;
      rsv_key   = rk;
      chk_key1  = c1;
      chk_key2  = c2;
   endtask

   task automatic check_port(input string name, input logic en, input logic [4:0] k,
                             input logic [31:0] val, input logic [31:0] busy);
      check({name, ".en"},    32'(rf_portD_enable), 32'(en));
      check({name, ".key"},   32'(rf_portD_key),    32'(k));
      check({name, ".value"}, rf_portD_value,       val);
      check({name, ".busy"},  busy_mask,            busy);
   endtask

   task automatic add(input string name, input logic [1:0] v,
                      input logic [4:0] k0, input logic [31:0] v0,
                      input logic [4:0] k1, input logic [31:0] v1,
                      input logic rv, input logic [4:0] rk, input logic [4:0] c1,
                      input logic [4:0] c2, input logic [1:0] er, input logic eh,
                      input logic ee, input logic [4:0] ek, input logic [31:0] ev,
                      input logic [31:0] eb);
      vec_t t;
      t.name = name; t.valid = v; t.k0 = k0; t.v0 = v0; t.k1 = k1; t.v1 = v1;
      t.rv = rv; t.rk = rk; t.c1 = c1; t.c2 = c2;
      t.e_ready = er; t.e_hazard = eh; t.e_en = ee; t.e_key = ek; t.e_value = ev;
      t.e_busy = eb;
      vecs.push_back(t);
   endtask

   initial begin
      // name      valid k0  v0          k1  v1          rv rk  c1 c2  rdy hz en key val          busy
      add("cont_a",  2'b11, 5, 32'hAAAA,  6, 32'hBBBB,  0, 0,  0, 0, 2'b01, 0, 1, 5,  32'hAAAA, 32'h0);
      add("cont_b",  2'b11, 8, 32'h1111,  6, 32'hBBBB,  0, 0,  0, 0, 2'b10, 0, 1, 6,  32'hBBBB, 32'h0);
      add("cont_c",  2'b11, 8, 32'h1111, 10, 32'h2222,  0, 0,  0, 0, 2'b01, 0, 1, 8,  32'h1111, 32'h0);
      add("cont_d",  2'b10, 0, 32'h0,    10, 32'h2222,  0, 0,  0, 0, 2'b10, 0, 1, 10, 32'h2222, 32'h0);
      add("idle",    2'b00, 0, 32'h0,     0, 32'h0,     0, 0,  0, 0, 2'b00, 0, 0, 10, 32'h2222, 32'h0);
      add("sb_rsv7", 2'b00, 0, 32'h0,     0, 32'h0,     1, 7,  0, 0, 2'b00, 0, 0, 10, 32'h2222, 32'h80);
      add("sb_chk7", 2'b00, 0, 32'h0,     0, 32'h0,     0, 0,  7, 0, 2'b00, 1, 0, 10, 32'h2222, 32'h80);
      add("sb_wb7",  2'b01, 7, 32'hC0DE,  0, 32'h0,     0, 0,  7, 0, 2'b01, 1, 1, 7,  32'hC0DE, 32'h0);
      add("sb_post", 2'b00, 0, 32'h0,     0, 32'h0,     0, 0,  7, 0, 2'b00, 0, 0, 7,  32'hC0DE, 32'h0);
      add("sb_rs12", 2'b00, 0, 32'h0,     0, 32'h0,     1, 12, 0, 0, 2'b00, 0, 0, 7,  32'hC0DE, 32'h1000);
      add("sb_wb12", 2'b10, 0, 32'h0,    12, 32'h5A5A,  0, 0,  0, 12, 2'b10, 1, 1, 12, 32'h5A5A, 32'h0);
      add("x0_rsv",  2'b00, 0, 32'h0,     0, 32'h0,     1, 0,  0, 0, 2'b00, 0, 0, 12, 32'h5A5A, 32'h0);
      add("x0_wb",   2'b01, 0, 32'hDEAD,  0, 32'h0,     0, 0,  0, 0, 2'b01, 0, 0, 12, 32'h5A5A, 32'h0);

      // Reset held two cycles with both requesters already valid.
      reset = 1'b0;
      drive(2'b11, 5, 32'hAAAA, 6, 32'hBBBB, 0, 0, 0, 0);
      #1;
      check("rst.ready", 32'(req_ready), 32'h0);
      tick();
      tick();
      check("rst.ready2", 32'(req_ready), 32'h0);
      check_port("rst", 0, 0, 32'h0, 32'h0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].k0, vecs[i].v0, vecs[i].k1, vecs[i].v1,
               vecs[i].rv, vecs[i].rk, vecs[i].c1, vecs[i].c2);
         #1;
         check({vecs[i].name, ".ready"},  32'(req_ready), 32'(vecs[i].e_ready));
         check({vecs[i].name, ".hazard"}, 32'(hazard),    32'(vecs[i].e_hazard));
         tick();
         check_port(vecs[i].name, vecs[i].e_en, vecs[i].e_key, vecs[i].e_value, vecs[i].e_busy);
      end

      // Reserve and write back x9 in the same cycle: the reservation survives.
      drive(2'b01, 9, 32'h9999, 0, 32'h0, 1, 9, 0, 0);
      #1;
      check("sim.ready", 32'(req_ready), 32'h1);
      check("sim.hazard", 32'(hazard), 32'h0);
      tick();
      check_port("sim", 1, 9, 32'h9999, 32'h200);
      // Probe the reserve-side hazard term without letting the reserve reach an edge.
      drive(2'b00, 0, 32'h0, 0, 32'h0, 1, 9, 0, 0);
      #1;
      check("sim.rsv_hazard", 32'(hazard), 32'h1);
      rsv_valid = 1'b0;
      #1;
      check("sim.no_rsv_hazard", 32'(hazard), 32'h0);
      tick();
      check_port("sim_idle", 0, 9, 32'h9999, 32'h200);

      // Mid-operation reset.
      drive(2'b00, 0, 32'h0, 0, 32'h0, 1, 3, 0, 0);
      tick();
      check("mid.busy3", busy_mask, 32'h208);
      drive(2'b00, 0, 32'h0, 0, 32'h0, 1, 4, 0, 0);
      tick();
      check("mid.busy4", busy_mask, 32'h218);
      drive(2'b10, 0, 32'h0, 3, 32'h3333, 0, 0, 0, 0);
      #1;
      check("mid.g1.ready", 32'(req_ready), 32'h2);
      tick();
      check_port("mid.g1", 1, 3, 32'h3333, 32'h210);
      drive(2'b01, 4, 32'h4444, 0, 32'h0, 0, 0, 0, 0);
      #1;
      check("mid.g0.ready", 32'(req_ready), 32'h1);
      tick();
      check_port("mid.g0", 1, 4, 32'h4444, 32'h200);
      reset = 1'b0;
      drive(2'b11, 4, 32'h4444, 3, 32'h3333, 0, 0, 0, 0);
      #1;
      check("mid.rst.ready", 32'(req_ready), 32'h0);
      tick();
      check_port("mid.rst", 0, 0, 32'h0, 32'h0);
      reset = 1'b1;
      #1;
      check("mid.after.ready", 32'(req_ready), 32'h1);
      tick();
      check_port("mid.after", 1, 4, 32'h4444, 32'h0);
      drive(2'b10, 0, 32'h0, 3, 32'h3333, 0, 0, 0, 0);
      #1;
      check("mid.req1.ready", 32'(req_ready), 32'h2);
      tick();
      check_port("mid.req1", 1, 3, 32'h3333, 32'h0);
      drive(2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
      tick();
      check_port("mid.idle", 0, 3, 32'h3333, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
